// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: opcodes, FSM states, op classifiers.
`default_nettype none

package muldiv_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MADD  = 4'd4;
  localparam logic [3:0] MD_MADDU = 4'd5;
  localparam logic [3:0] MD_MSUB  = 4'd6;
  localparam logic [3:0] MD_MSUBU = 4'd7;
  localparam logic [3:0] MD_MTHI  = 4'd8;
  localparam logic [3:0] MD_MTLO  = 4'd9;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } md_state_t;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_div_step.sv
// One combinational restoring-division iteration on a {remainder, quotient} shift pair.
`default_nettype none

module md_div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  // Remainder stays below the divisor, so the shifted value always fits in 33 bits.
  assign shifted = {rem_in, quo_in[31]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = ~diff[32];
  assign rem_out = fits ? diff[31:0] : shifted[31:0];
  assign quo_out = {quo_in[30:0], fits};

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO, with busy/stall handshake for MFHI/MFLO.
`default_nettype none

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [3:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iFlush,
  input  logic        iRead,
  output logic        oBusy,
  output logic        oStall,
  output logic        oDone,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  md_state_t   state, state_nxt;
  logic [5:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_mag, b_mag, a_raw;
  logic        neg_q, neg_r;
  logic [31:0] rem_q, quo_q, rem_nxt, quo_nxt;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic [63:0] mul_pipe [MUL_LAT];

  logic        start_ok;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod, acc, fin;
  logic [31:0] quo_s, rem_s;

  assign start_ok = iStart & ~iFlush & (state == ST_IDLE);
  assign a_neg    = is_signed_op(iOp) & iA[31];
  assign b_neg    = is_signed_op(iOp) & iB[31];
  assign a_abs    = a_neg ? -iA : iA;
  assign b_abs    = b_neg ? -iB : iB;

  md_div_step u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (b_mag),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok && is_mul_op(iOp))      state_nxt = ST_MUL;
        else if (start_ok && is_div_op(iOp)) state_nxt = ST_DIV;
      end
      ST_MUL:    if (cnt == 6'd1) state_nxt = ST_FINISH;
      ST_DIV:    if (cnt == 6'd1) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (iFlush) state_nxt = ST_IDLE;
  end

  // Product of magnitudes; operands hold steady while in MUL, so the pipe tail is valid at FINISH.
  always_ff @(posedge iCLK) begin
    mul_pipe[0] <= {32'd0, a_mag} * {32'd0, b_mag};
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  always_comb begin
    prod  = neg_q ? -mul_pipe[MUL_LAT-1] : mul_pipe[MUL_LAT-1];
    acc   = {hi_q, lo_q};
    quo_s = neg_q ? -quo_q : quo_q;
    rem_s = neg_r ? -rem_q : rem_q;
    fin   = prod;
    case (op_q)
      MD_MADD, MD_MADDU: fin = acc + prod;
      MD_MSUB, MD_MSUBU: fin = acc - prod;
      MD_DIV, MD_DIVU:   fin = (b_mag == 32'd0) ? {a_raw, 32'hFFFF_FFFF} : {rem_s, quo_s};
      default:           fin = prod;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt    <= 6'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            op_q  <= iOp;
            a_mag <= a_abs;
            b_mag <= b_abs;
            a_raw <= iA;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            rem_q <= 32'd0;
            quo_q <= a_abs;
            if (is_mul_op(iOp)) cnt <= 6'(MUL_LAT);
            if (is_div_op(iOp)) cnt <= 6'(DIV_STEPS);
            if (iOp == MD_MTHI) begin
              hi_q   <= iA;
              done_q <= 1'b1;
            end
            if (iOp == MD_MTLO) begin
              lo_q   <= iA;
              done_q <= 1'b1;
            end
          end
        end
        ST_MUL: cnt <= cnt - 6'd1;
        ST_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - 6'd1;
        end
        ST_FINISH: begin
          if (!iFlush) begin
            hi_q   <= fin[63:32];
            lo_q   <= fin[31:0];
            done_q <= 1'b1;
          end
        end
        default: cnt <= 6'd0;
      endcase
    end
  end

  assign oBusy  = (state != ST_IDLE);
  assign oStall = iRead & oBusy;
  assign oDone  = done_q;
  assign oHI    = hi_q;
  assign oLO    = lo_q;

endmodule

`default_nettype wire
